// File: rtl/pck_len_fifo_pkg.sv
// Shared defaults and the per-channel pointer record for the multi-channel
// packet-length FIFO.
package pck_len_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_DEPTH      = 32;
    localparam int DEF_NUM_CH     = 4;

    // Pointer storage is sized for the largest supported DEPTH (65536); the
    // FIFO masks every update so bits above ADDR_WIDTH always stay zero.
    localparam int PTR_MAX_W = 17;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    typedef struct packed {
        ptr_t wr;   // speculative write pointer
        ptr_t cm;   // committed write pointer
        ptr_t rd;   // read pointer
    } ch_ptr_t;

endpackage

// File: rtl/pck_len_mc_ram.sv
// Shared storage for all channels: one write port and one read port.
// The read is registered, and clr zeroes the read register without touching storage.
module pck_len_mc_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int WORDS      = 128,
    parameter int AW         = 7
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (clr)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/pck_len_fifo_mc.sv
// Multi-channel packet-length FIFO: writes are speculative until committed,
// can be dropped as a group, and only committed entries are readable.
module pck_len_fifo_mc
    import pck_len_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int CH_WIDTH   = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           hw_rst,
    input  logic                           sw_rst,
    input  logic                           wr_en,
    input  logic [CH_WIDTH-1:0]            wr_ch,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           wr_commit,
    input  logic                           wr_drop,
    input  logic                           rd_en,
    input  logic [CH_WIDTH-1:0]            rd_ch,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic [CH_WIDTH-1:0]            rd_data_ch,
    input  logic [ADDR_WIDTH-1:0]          af_thr,
    input  logic [ADDR_WIDTH-1:0]          ae_thr,
    output logic [NUM_CH-1:0]              full,
    output logic [NUM_CH-1:0]              empty,
    output logic [NUM_CH-1:0]              almost_full,
    output logic [NUM_CH-1:0]              almost_empty,
    output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] level,
    output logic                           overflow,
    output logic                           underflow,
    output logic [CH_WIDTH-1:0]            err_ch
);

    localparam int   PW       = ADDR_WIDTH + 1;
    localparam ptr_t PTR_MASK = ptr_t'({PW{1'b1}});
    localparam ptr_t WRAP_BIT = ptr_t'(1) << ADDR_WIDTH;

    function automatic ptr_t inc(input ptr_t p);
        return (p + ptr_t'(1)) & PTR_MASK;
    endfunction

    ch_ptr_t st     [NUM_CH];
    ch_ptr_t st_nxt [NUM_CH];

    logic rst;
    logic wr_ok, rd_ok, ovf, unf;

    assign rst = hw_rst || sw_rst;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_flag
        logic [PW-1:0] lvl, used;
        assign used = PW'(st[c].wr - st[c].rd);
        assign lvl  = PW'(st[c].cm - st[c].rd);
        assign full[c]         = (st[c].wr ^ st[c].rd) == WRAP_BIT;
        assign empty[c]        = st[c].cm == st[c].rd;
        assign level[c*PW +: PW] = lvl;
        assign almost_full[c]  = used >= PW'(DEPTH) - {1'b0, af_thr};
        assign almost_empty[c] = lvl <= {1'b0, ae_thr};
    end

    // A drop in the same cycle swallows the write without an overflow.
    assign wr_ok = wr_en && !full[wr_ch] && !wr_drop;
    assign ovf   = wr_en &&  full[wr_ch] && !wr_drop;
    assign rd_ok = rd_en && !empty[rd_ch];
    assign unf   = rd_en &&  empty[rd_ch];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            st_nxt[c] = st[c];
            if (CH_WIDTH'(c) == wr_ch) begin
                if (wr_drop) begin
                    st_nxt[c].wr = st[c].cm;
                end else begin
                    if (wr_ok)
                        st_nxt[c].wr = inc(st[c].wr);
                    // commit takes the post-write pointer so a same-cycle write is included
                    if (wr_commit)
                        st_nxt[c].cm = st_nxt[c].wr;
                end
            end
            if (CH_WIDTH'(c) == rd_ch && rd_ok)
                st_nxt[c].rd = inc(st[c].rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                st[c] <= '0;
            rd_valid   <= 1'b0;
            rd_data_ch <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            err_ch     <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                st[c] <= st_nxt[c];
            rd_valid  <= rd_ok;
            overflow  <= ovf;
            underflow <= unf;
            if (rd_ok)
                rd_data_ch <= rd_ch;
            if (ovf)
                err_ch <= wr_ch;
            else if (unf)
                err_ch <= rd_ch;
        end
    end

    pck_len_mc_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (NUM_CH * DEPTH),
        .AW         (CH_WIDTH + ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .clr   (rst),
        .we    (wr_ok),
        .waddr ({wr_ch, st[wr_ch].wr[ADDR_WIDTH-1:0]}),
        .wdata (wr_data),
        .re    (rd_ok && !rst),
        .raddr ({rd_ch, st[rd_ch].rd[ADDR_WIDTH-1:0]}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_pck_len_fifo_mc.sv
// Randomized scoreboard bench for pck_len_fifo_mc against a queue-based
// model of per-channel pending and committed entries.
module tb_pck_len_fifo_mc;

    localparam int DW    = 12;
    localparam int DEPTH = 32;
    localparam int NCH   = 4;
    localparam int AW    = 5;
    localparam int CW    = 2;
    localparam int PW    = AW + 1;

    bit clk;
    logic hw_rst, sw_rst, wr_en, wr_commit, wr_drop, rd_en;
    logic [CW-1:0] wr_ch, rd_ch, rd_data_ch, err_ch;
    logic [DW-1:0] wr_data, rd_data;
    logic [AW-1:0] af_thr, ae_thr;
    logic [NCH-1:0] full, empty, almost_full, almost_empty;
    logic [NCH*PW-1:0] level;
    logic rd_valid, overflow, underflow;

    typedef struct {
        bit            vld;
        bit            dchk;
        logic [DW-1:0] data;
        logic [CW-1:0] ch;
        bit            ovf;
        bit            unf;
        logic [CW-1:0] ech;
    } exp_t;

    exp_t          expq [$];
    logic [DW-1:0] cmq [NCH][$];
    logic [DW-1:0] pdq [NCH][$];
    int checks = 0;
    int errors = 0;

    pck_len_fifo_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk(clk), .hw_rst(hw_rst), .sw_rst(sw_rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_drop(wr_drop),
        .rd_en(rd_en), .rd_ch(rd_ch),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_data_ch(rd_data_ch),
        .af_thr(af_thr), .ae_thr(ae_thr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags as seen from queue occupancy: total held = pending + committed.
    task automatic check_flags();
        logic [NCH-1:0]    ef, ee, eaf, eae;
        logic [NCH*PW-1:0] el;
        int n, t;
        el = '0;
        for (int c = 0; c < NCH; c++) begin
            n = cmq[c].size();
            t = n + pdq[c].size();
            ef[c]  = (t == DEPTH);
            ee[c]  = (n == 0);
            eaf[c] = (t >= DEPTH - int'(af_thr));
            eae[c] = (n <= int'(ae_thr));
            el[c*PW +: PW] = PW'(n);
        end
        check("full", 32'(full), 32'(ef));
        check("empty", 32'(empty), 32'(ee));
        check("almost_full", 32'(almost_full), 32'(eaf));
        check("almost_empty", 32'(almost_empty), 32'(eae));
        check("level", 32'(level), 32'(el));
    endtask

    task automatic step(input bit hr, input bit sr, input bit we, input int wc,
                        input logic [DW-1:0] wd, input bit cm, input bit dr,
                        input bit re, input int rc);
        exp_t e;
        bit emp_r, full_w;
        logic [CW-1:0] wcs, rcs;
        wcs = wc[CW-1:0];
        rcs = rc[CW-1:0];
        hw_rst = hr; sw_rst = sr;
        wr_en = we; wr_ch = wcs; wr_data = wd; wr_commit = cm; wr_drop = dr;
        rd_en = re; rd_ch = rcs;
        e.vld = 0; e.dchk = 0; e.data = '0; e.ch = '0; e.ovf = 0; e.unf = 0; e.ech = '0;
        if (hr || sr) begin
            for (int c = 0; c < NCH; c++) begin
                cmq[c].delete();
                pdq[c].delete();
            end
            e.dchk = 1;
        end else begin
            emp_r  = (cmq[rcs].size() == 0);
            full_w = (cmq[wcs].size() + pdq[wcs].size() == DEPTH);
            if (re && !emp_r) begin
                e.vld  = 1;
                e.data = cmq[rcs].pop_front();
                e.ch   = rcs;
            end
            if (dr) begin
                pdq[wcs].delete();
            end else begin
                if (we && !full_w) pdq[wcs].push_back(wd);
                if (we && full_w) e.ovf = 1;
                if (cm)
                    while (pdq[wcs].size() > 0) cmq[wcs].push_back(pdq[wcs].pop_front());
            end
            if (re && emp_r) e.unf = 1;
            if (e.ovf) e.ech = wcs;
            else if (e.unf) e.ech = rcs;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
        check_flags();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d, input bit cm);
        step(0, 0, 1, ch, d, cm, 0, 0, 0);
    endtask

    task automatic rd(input int ch);
        step(0, 0, 0, 0, '0, 0, 0, 1, ch);
    endtask

    // Response monitor: one expectation record per clock, popped on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(e.vld));
            if (e.vld || e.dchk) begin
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_data_ch", 32'(rd_data_ch), 32'(e.ch));
            end
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("underflow", 32'(underflow), 32'(e.unf));
            if (e.ovf || e.unf || e.dchk)
                check("err_ch", 32'(err_ch), 32'(e.ech));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        af_thr = 5'd4;
        ae_thr = 5'd4;
        step(1, 0, 0, 0, '0, 0, 0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0, 0, 0);

        // uncommitted writes stay invisible until committed
        for (int i = 0; i < 3; i++) wr(1, DW'(12'h100 + i), 0);
        step(0, 0, 0, 1, '0, 1, 0, 0, 0);

        // drop discards pending entries and wins over a same-cycle write/commit
        for (int i = 0; i < 5; i++) wr(2, DW'(12'h200 + i), 0);
        step(0, 0, 1, 2, 12'h7FF, 1, 1, 0, 0);
        wr(2, 12'h0AB, 1);
        rd(2);
        idle();

        // fill ch0, then overflow
        for (int i = 0; i < DEPTH; i++) wr(0, DW'($urandom), 1);
        wr(0, 12'h555, 1);
        idle();

        // underflow on empty ch3
        rd(3);
        idle();

        // wrap-around on ch1
        for (int i = 0; i < 3; i++) rd(1);
        for (int i = 0; i < 40; i++) begin
            wr(1, DW'(12'h300 + i), 1);
            rd(1);
        end

        // simultaneous write+commit and read at level 1, then software reset
        for (int i = 0; i < DEPTH - 1; i++) rd(0);
        step(0, 0, 1, 0, 12'h9C3, 1, 0, 1, 0);
        idle();
        wr(2, 12'h011, 1);
        step(0, 1, 1, 2, 12'h022, 1, 0, 1, 2);
        idle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            if (i % 100 == 0) begin
                af_thr = AW'($urandom_range(0, DEPTH - 1));
                ae_thr = AW'($urandom_range(0, DEPTH - 1));
            end
            r = $urandom_range(0, 399);
            step(r == 1, r == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, NCH - 1), DW'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, NCH - 1));
        end

        idle();
        idle();
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pck_len_fifo_mc.md
PCK_LEN_FIFO_MC -- requirements
Module: pck_len_fifo_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, packet-length entry width.
REQ-002 SHALL have parameter DEPTH, default 32, entries per channel; power of two, at least 2.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent channels, at least 2.
REQ-004 SHALL derive ADDR_WIDTH = clog2(DEPTH) and CH_WIDTH = clog2(NUM_CH) as localparams.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- hw_rst  in  1  synchronous, active-high reset.
- sw_rst  in  1  synchronous, active-high software reset.
- wr_en  in  1  write one entry.
- wr_ch  in  CH_WIDTH  target channel for write, commit and drop.
- wr_data  in  DATA_WIDTH  entry to write.
- wr_commit  in  1  make all pending entries of wr_ch readable.
- wr_drop  in  1  discard all pending entries of wr_ch.
- rd_en  in  1  read one entry.
- rd_ch  in  CH_WIDTH  channel to read.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- rd_data_ch  out  CH_WIDTH  channel of rd_data.
- af_thr, ae_thr  in  ADDR_WIDTH  almost-full and almost-empty thresholds, shared by all channels.
- full, empty, almost_full, almost_empty  out  NUM_CH  per-channel flags.
- level  out  NUM_CH*(ADDR_WIDTH+1)  committed fill per channel; channel c occupies slice c.
- overflow, underflow  out  1  one-cycle error pulses.
- err_ch  out  CH_WIDTH  channel that caused the error pulse.

Function
REQ-006 SHALL keep three pointers per channel (wr_ptr speculative, cm_ptr committed, rd_ptr), each ADDR_WIDTH+1 bits, with the MSB as wrap bit; all arithmetic is modulo 2^(ADDR_WIDTH+1).
REQ-007 SHALL compute full[c] = 1 when wr_ptr and rd_ptr differ only in the MSB.
REQ-008 SHALL compute empty[c] = (cm_ptr == rd_ptr); uncommitted entries are never readable.
REQ-009 SHALL compute level[c] = cm_ptr - rd_ptr.
REQ-010 SHALL compute almost_full[c] = ((wr_ptr - rd_ptr) >= DEPTH - af_thr) and almost_empty[c] = (level[c] <= ae_thr); all flags are combinational from registered pointers.
REQ-011 SHALL accept a write when wr_en=1, full[wr_ch]=0 and wr_drop=0: store wr_data at {wr_ch, wr_ptr[ADDR_WIDTH-1:0]} and increment wr_ptr.
REQ-012 SHALL, on wr_commit=1 with wr_drop=0, set cm_ptr of wr_ch to the post-write wr_ptr, so a same-cycle accepted write is included in the commit.
REQ-013 SHALL, on wr_drop=1, set wr_ptr of wr_ch to cm_ptr; drop wins over a same-cycle wr_en and wr_commit, and the discarded write raises no overflow.
REQ-014 SHALL accept a read when rd_en=1 and empty[rd_ch]=0: increment rd_ptr, and on the next cycle drive rd_valid=1, rd_data and rd_data_ch; otherwise rd_valid=0 and rd_data holds its value.
REQ-015 SHALL allow a read and a write/commit on the same or different channels in one cycle; a read sees only entries committed before that cycle.
REQ-016 SHALL pulse overflow=1 for one cycle, the cycle after wr_en=1 with full[wr_ch]=1 and wr_drop=0, with err_ch=wr_ch; the pointers do not change.
REQ-017 SHALL pulse underflow=1 for one cycle, the cycle after rd_en=1 with empty[rd_ch]=1, with err_ch=rd_ch; if both errors occur in the same cycle, overflow's channel is reported.
REQ-018 SHALL leave all other channels' state unchanged by any single-channel operation.

Reset
REQ-019 SHALL, on hw_rst=1 or sw_rst=1 at a clock edge, clear every pointer and set rd_valid=0, rd_data=0, rd_data_ch=0, overflow=0, underflow=0, err_ch=0.
REQ-020 SHALL present, after reset, empty and almost_empty all ones, full and almost_full all zeros, and level all zeros.
REQ-021 SHALL not reset storage contents; reset mid-operation discards pending and committed entries and suppresses any read response due that cycle.

Structure
REQ-022 SHALL place default parameter values and a per-channel pointer struct (wr, cm, rd) in package pck_len_fifo_pkg.
REQ-023 SHALL use one sub-module, pck_len_mc_ram: a 1-write, 1-read, NUM_CH*DEPTH x DATA_WIDTH RAM with a registered read.

Verification
REQ-024 SHALL cover: reset, then write 3 entries to ch1 without commit -> empty[1]=1, level[1]=0; then commit -> level[1]=3, almost_empty[1]=1 with ae_thr=4.
REQ-025 SHALL cover: write 5 entries to ch2, then drop -> wr_ptr back to 0, empty[2]=1; a next write of 0x0AB plus commit, then read -> rd_valid one cycle later with rd_data=0x0AB, rd_data_ch=2.
REQ-026 SHALL cover: fill ch0 with 32 committed writes -> full[0]=1, level[0]=32; a 33rd write -> overflow pulse, err_ch=0, level unchanged; other channels remain empty.
REQ-027 SHALL cover: rd_en on empty ch3 -> underflow pulse with err_ch=3, rd_valid=0.
REQ-028 SHALL cover: wrap-around on ch1 (40 write/commit/read pairs) -> data in order, level oscillating between 0 and 1.
REQ-029 SHALL cover: simultaneous write+commit on ch0 and read on ch0 with level 1 -> level stays 1; sw_rst mid-stream -> all flags at reset values the next cycle.
